// File: rtl/if_id_hazard_ctrl_pkg.sv
// Shared MIPS encodings for the IF/ID hazard controller: opcodes, bubble
// instruction and control FSM states.
package if_id_hazard_ctrl_pkg;

  localparam logic [31:0] MIPS_NOP   = 32'h0000_0000;
  localparam logic [5:0]  MIPS_OP_J  = 6'b000010;
  localparam logic [5:0]  MIPS_OP_LW = 6'b100011;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STALL    = 2'd1,
    ST_REDIRECT = 2'd2
  } hz_state_t;

  function automatic logic [5:0] opcode(input logic [31:0] i);
    return i[31:26];
  endfunction

  function automatic logic [4:0] rs_f(input logic [31:0] i);
    return i[25:21];
  endfunction

  function automatic logic [4:0] rt_f(input logic [31:0] i);
    return i[20:16];
  endfunction

endpackage

// File: rtl/if_id_hazard_detect.sv
// Load-use comparator: a load in EX whose destination feeds either source of
// the instruction sitting in decode.
module hazard_detect
  import if_id_hazard_ctrl_pkg::*;
#(
  parameter logic [5:0] OP_LW = MIPS_OP_LW
) (
  input  logic [31:0] ex_ins,
  input  logic [31:0] if_id_ins,
  output logic        load_use
);

  logic [4:0] w_ld_rt;
  logic       w_is_lw;
  logic       w_unused;

  assign w_ld_rt = rt_f(ex_ins);
  assign w_is_lw = (opcode(ex_ins) == OP_LW);

  // r0 is hardwired zero, so a load into it never creates a dependency.
  assign load_use = w_is_lw && (w_ld_rt != 5'd0) &&
                    ((w_ld_rt == rs_f(if_id_ins)) || (w_ld_rt == rt_f(if_id_ins)));

  assign w_unused = ^{ex_ins[25:21], ex_ins[15:0], if_id_ins[31:26], if_id_ins[15:0]};

endmodule

// File: rtl/if_id_hazard_ctrl.sv
// IF/ID pipeline register with load-use stall, EX-branch flush and decode-stage
// jump redirect. Priority: EX branch > load-use > jump.
module if_id_hazard_ctrl
  import if_id_hazard_ctrl_pkg::*;
#(
  parameter logic [31:0] NOP   = MIPS_NOP,
  parameter logic [5:0]  OP_J  = MIPS_OP_J,
  parameter logic [5:0]  OP_LW = MIPS_OP_LW
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ins,
  input  logic [15:0] current_address,
  input  logic        ex_branch_taken,
  input  logic [15:0] ex_branch_target,
  output logic [15:0] jmp_loc,
  output logic        pc_mux_sel,
  output logic        stall,
  output logic        stall_pm,
  output logic [31:0] if_id_ins,
  output logic [15:0] if_id_pc,
  output logic [31:0] ex_ins,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  logic [31:0] r_if_id_ins;
  logic [15:0] r_if_id_pc;
  logic [31:0] r_ex_ins;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;
  hz_state_t   r_state;

  logic w_load_use;
  logic w_branch;
  logic w_stall;
  logic w_jump;
  logic w_redirect;

  hazard_detect #(.OP_LW(OP_LW)) u_hazard_detect (
    .ex_ins    (r_ex_ins),
    .if_id_ins (r_if_id_ins),
    .load_use  (w_load_use)
  );

  assign w_branch   = ex_branch_taken;
  assign w_stall    = w_load_use && !w_branch;
  // A jump waiting behind a load-use is deferred; it fires once the bubble clears.
  assign w_jump     = (opcode(r_if_id_ins) == OP_J) && !w_branch && !w_load_use;
  assign w_redirect = w_branch || w_jump;

  assign stall      = w_stall;
  assign pc_mux_sel = w_redirect;
  assign jmp_loc    = w_branch ? ex_branch_target :
                      w_jump   ? r_if_id_ins[15:0] : 16'h0000;

  assign if_id_ins   = r_if_id_ins;
  assign if_id_pc    = r_if_id_pc;
  assign ex_ins      = r_ex_ins;
  assign stall_count = r_stall_cnt;
  assign flush_count = r_flush_cnt;
  // STALL state is entered exactly on the edge that ends a stall cycle.
  assign stall_pm    = (r_state == ST_STALL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_if_id_ins <= NOP;
      r_if_id_pc  <= 16'h0000;
      r_ex_ins    <= NOP;
      r_stall_cnt <= 16'h0000;
      r_flush_cnt <= 16'h0000;
      r_state     <= ST_RUN;
    end else begin
      if (w_branch) begin
        r_if_id_ins <= NOP;
        r_if_id_pc  <= current_address;
        r_ex_ins    <= NOP;
      end else if (w_stall) begin
        r_ex_ins    <= NOP;
      end else if (w_jump) begin
        r_if_id_ins <= NOP;
        r_if_id_pc  <= current_address;
        r_ex_ins    <= r_if_id_ins;
      end else begin
        r_if_id_ins <= ins;
        r_if_id_pc  <= current_address;
        r_ex_ins    <= r_if_id_ins;
      end

      if (w_stall && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_redirect && (r_flush_cnt != 16'hFFFF))
        r_flush_cnt <= r_flush_cnt + 16'd1;

      if (w_redirect)   r_state <= ST_REDIRECT;
      else if (w_stall) r_state <= ST_STALL;
      else              r_state <= ST_RUN;
    end
  end

endmodule

// File: doc/if_id_hazard_ctrl.md
IF_ID_HAZARD_CTRL -- requirements
Module: if_id_hazard_ctrl

Interface
REQ-001 SHALL have parameter NOP, default 32'h0000_0000, meaning the bubble instruction loaded into pipeline registers.
REQ-002 SHALL have parameter OP_J, default 6'b000010, meaning the jump opcode; OP_LW, default 6'b100011, meaning the load opcode.
REQ-003 SHALL have port clk, input, 1, meaning the single rising-edge clock.
REQ-004 SHALL have port reset, input, 1, meaning the asynchronous active-low reset (0 = reset).
REQ-005 SHALL have port ins, input, 32, meaning the fetched instruction from the PC/instruction-memory stage.
REQ-006 SHALL have port current_address, input, 16, meaning the fetch address of ins.
REQ-007 SHALL have ports ex_branch_taken, input, 1, and ex_branch_target, input, 16, meaning the branch resolved in EX and its target.
REQ-008 SHALL have ports jmp_loc, output, 16; pc_mux_sel, output, 1; stall, output, 1; stall_pm, output, 1; all drive the fetch stage.
REQ-009 SHALL have ports if_id_ins, output, 32, and if_id_pc, output, 16, meaning the decode-stage instruction and address.
REQ-010 SHALL have ports ex_ins, output, 32, meaning the EX-stage instruction.
REQ-011 SHALL have ports stall_count, output, 16, and flush_count, output, 16, meaning saturating event counters.

Function
REQ-012 SHALL register if_id_ins/if_id_pc from ins/current_address and ex_ins from if_id_ins each cycle unless held or flushed.
REQ-013 SHALL flag load-use when ex_ins[31:26]==OP_LW, ex_ins[20:16]!=0, and ex_ins[20:16] equals if_id_ins[25:21] or if_id_ins[20:16].
REQ-014 On load-use: stall=1 combinationally in that cycle; if_id_ins/if_id_pc hold; ex_ins loads NOP at the next edge; stall lasts exactly one cycle.
REQ-015 SHALL register stall_pm as stall delayed by one cycle.
REQ-016 On ex_branch_taken=1: pc_mux_sel=1, jmp_loc=ex_branch_target in the same cycle; if_id_ins and ex_ins load NOP at the next edge.
REQ-017 On if_id_ins[31:26]==OP_J (no branch, no load-use): pc_mux_sel=1, jmp_loc=if_id_ins[15:0]; if_id_ins loads NOP at the next edge; ex_ins advances normally.
REQ-018 Priority SHALL be EX branch > load-use > jump; with EX branch, stall=0 and load-use is suppressed.
REQ-019 During load-use with a J in decode, the jump SHALL be deferred until the stall clears.
REQ-020 When no redirect is active, pc_mux_sel=0 and jmp_loc=16'h0000.
REQ-021 stall_count SHALL increment on each cycle with stall=1; flush_count SHALL increment on each redirect cycle; both saturate at 16'hFFFF.
REQ-022 Internal state SHALL be a 3-state FSM: RUN, STALL (load-use cycle), REDIRECT (flush cycle); any state returns to RUN when no event is present.

Reset
REQ-023 While reset=0: if_id_ins=NOP, if_id_pc=0, ex_ins=NOP, stall_pm=0, counters=0, FSM=RUN; combinational outputs SHALL derive from these values.
REQ-024 Reset assertion mid-stall or mid-redirect SHALL clear all state immediately; the first edge after release SHALL capture ins normally.

Structure
REQ-025 Opcode constants, NOP, and FSM state encodings SHALL live in a shared MIPS package used by the decoder and control.
REQ-026 The hazard comparator SHALL be a sub-module, hazard_detect, that is purely combinational and takes ex_ins and if_id_ins.

Verification
REQ-027 LW r3 in EX, ADD r4,r3,r5 in decode -> stall=1 for one cycle, stall_pm=1 next cycle, ex_ins=NOP, stall_count=1.
REQ-028 J 0x0040 enters decode -> pc_mux_sel=1, jmp_loc=16'h0040 for one cycle; next if_id_ins=NOP; flush_count=1.
REQ-029 ex_branch_taken=1, target 16'h0010, with load-use present -> stall=0, jmp_loc=16'h0010; if_id_ins and ex_ins=NOP.
REQ-030 LW r0 in EX with a dependent r0 reader -> no stall.
REQ-031 Force 70000 stall events -> stall_count holds at 16'hFFFF.
REQ-032 reset=0 asserted during the STALL cycle -> all outputs at reset values before the next clk edge.
